// File: rtl/mini_ram_arb.sv
// mini_ram_arb: two-port arbiter in front of a single-port sync RAM.
// Round-robin or fixed priority, bounded burst lock, 1-cycle read return.
module mini_ram_arb #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_fixed_pri,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic                 p0_lock,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [DATA_BITS-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [DATA_BITS-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic                 p1_lock,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [DATA_BITS-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DATA_BITS-1:0] p1_rdata,
  output logic                 ram_ce,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_din,
  input  logic [DATA_BITS-1:0] ram_dout
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  logic       last_gnt_q, last_gnt_d;
  logic       owner_vld_q, owner_vld_d;
  logic       owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;

  logic gnt_any;
  logic sel;
  logic own_req;
  logic lock_act;
  logic lock_g;

  // Grant selection; gated by rst_n so nothing is granted in reset
  always_comb begin
    own_req  = owner_q ? p1_req : p0_req;
    lock_act = owner_vld_q && (burst_cnt_q < MAXB) && own_req;
    gnt_any  = rst_n && (p0_req || p1_req);
    sel      = 1'b0;
    priority case (1'b1)
      !p1_req:       sel = 1'b0;
      !p0_req:       sel = 1'b1;
      lock_act:      sel = owner_q;
      cfg_fixed_pri: sel = 1'b0;
      default:       sel = ~last_gnt_q;
    endcase
    lock_g = sel ? p1_lock : p0_lock;
  end

  // RAM drive and per-port grant / read return
  always_comb begin
    p0_gnt    = gnt_any && !sel;
    p1_gnt    = gnt_any && sel;
    ram_ce    = gnt_any;
    ram_we    = gnt_any && (sel ? p1_we : p0_we);
    ram_addr  = (gnt_any && sel) ? p1_addr : p0_addr;
    ram_din   = (gnt_any && sel) ? p1_wdata : p0_wdata;
    p0_rvalid = rd_pend_q && !rd_port_q;
    p1_rvalid = rd_pend_q && rd_port_q;
    p0_rdata  = ram_dout;
    p1_rdata  = ram_dout;
  end

  // Next-state for history, lock ownership and pending read
  always_comb begin
    last_gnt_d  = last_gnt_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = gnt_any && !ram_we;
    rd_port_d   = sel;
    if (owner_vld_q && !own_req) owner_vld_d = 1'b0;
    if (gnt_any) begin
      last_gnt_d = sel;
      if (lock_g) begin
        owner_vld_d = 1'b1;
        owner_d     = sel;
        if (owner_vld_q && owner_q == sel)
          burst_cnt_d = (burst_cnt_q >= MAXB) ? MAXB : burst_cnt_q + 4'd1;
        else
          burst_cnt_d = 4'd1;
      end else if (owner_vld_q) begin
        // owner released, or the other port took over after a full burst
        owner_vld_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 1'b1;
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      burst_cnt_q <= 4'd0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_port_q   <= rd_port_d;
    end
  end

endmodule

// File: tb/tb_mini_ram_arb.sv
// tb_mini_ram_arb: scenario tasks with a read-return scoreboard
// and a behavioural RAM behind the arbiter.
module tb_mini_ram_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_fixed_pri;
  logic       p0_req, p0_we, p0_lock;
  logic [7:0] p0_addr, p0_wdata;
  logic       p0_gnt, p0_rvalid;
  logic [7:0] p0_rdata;
  logic       p1_req, p1_we, p1_lock;
  logic [7:0] p1_addr, p1_wdata;
  logic       p1_gnt, p1_rvalid;
  logic [7:0] p1_rdata;
  logic       ram_ce, ram_we;
  logic [7:0] ram_addr, ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  typedef struct {
    logic       port;
    logic [7:0] data;
  } rd_t;
  rd_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mini_ram_arb #(.ADDR_BITS(8), .DATA_BITS(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_fixed_pri(cfg_fixed_pri),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  task automatic idle_all();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  // One cycle: check read return, grants, then record expectations
  task automatic step(input logic e0, input logic e1, input string nm);
    rd_t h;
    @(negedge clk);
    n_cmp++;
    if (q.size() > 0) begin
      h = q.pop_front();
      if ({p0_rvalid, p1_rvalid} !== {!h.port, h.port}) begin
        n_bad++;
        $display("FAIL %s rvalid: got %b%b want %b%b", nm,
                 p0_rvalid, p1_rvalid, !h.port, h.port);
      end
      n_cmp++;
      if ((h.port ? p1_rdata : p0_rdata) !== h.data) begin
        n_bad++;
        $display("FAIL %s rdata p%0d: got %h want %h", nm, h.port,
                 h.port ? p1_rdata : p0_rdata, h.data);
      end
    end else if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s spurious rvalid: got %b%b want 00", nm,
               p0_rvalid, p1_rvalid);
    end
    n_cmp++;
    if ({p0_gnt, p1_gnt, ram_ce} !== {e0, e1, e0 | e1}) begin
      n_bad++;
      $display("FAIL %s gnt/ce: got %b%b%b want %b%b%b", nm,
               p0_gnt, p1_gnt, ram_ce, e0, e1, e0 | e1);
    end
    if (e0) begin
      if (p0_we) ref_mem[p0_addr] = p0_wdata;
      else q.push_back('{1'b0, ref_mem[p0_addr]});
    end
    if (e1) begin
      if (p1_we) ref_mem[p1_addr] = p1_wdata;
      else q.push_back('{1'b1, ref_mem[p1_addr]});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    p0_req = 1; p0_we = 1; p1_req = 1; p1_we = 1;
    @(negedge clk);
    n_cmp++;
    if ({p0_gnt, p1_gnt, ram_ce, ram_we, p0_rvalid, p1_rvalid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b%b%b%b%b%b want 000000",
               p0_gnt, p1_gnt, ram_ce, ram_we, p0_rvalid, p1_rvalid);
    end
    idle_all();
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_rr();
    p0_req = 1; p0_addr = 8'h01;
    p1_req = 1; p1_addr = 8'h02;
    step(1, 0, "rr0");
    step(0, 1, "rr1");
    step(1, 0, "rr2");
    step(0, 1, "rr3");
    idle_all();
    step(0, 0, "rr_drain");
  endtask

  task automatic test_single();
    p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 8'hA5;
    step(1, 0, "single_wr");
    p0_we = 0;
    step(1, 0, "single_rd");
    idle_all();
    step(0, 0, "single_drain");
  endtask

  task automatic test_fixed();
    cfg_fixed_pri = 1;
    p0_req = 1; p0_addr = 8'h03;
    p1_req = 1; p1_addr = 8'h04;
    for (int i = 0; i < 5; i++) step(1, 0, "fixed_p0");
    cfg_fixed_pri = 0;
    step(0, 1, "fixed_off_p1");
    idle_all();
    step(0, 0, "fixed_drain");
  endtask

  task automatic test_lock();
    p0_req = 1; p0_addr = 8'h05;
    step(1, 0, "lock_pre");
    p1_req = 1; p1_lock = 1; p1_addr = 8'h06;
    for (int i = 0; i < 4; i++) step(0, 1, "lock_burst");
    step(1, 0, "lock_yield");
    p0_req = 0;
    for (int i = 0; i < 8; i++) step(0, 1, "lock_alone");
    idle_all();
    step(0, 0, "lock_drain");
  endtask

  task automatic test_wrrd();
    p0_req = 1; p0_we = 1; p0_addr = 8'h20; p0_wdata = 8'h33;
    step(1, 0, "wrrd_wr");
    idle_all();
    p1_req = 1; p1_addr = 8'h20;
    step(0, 1, "wrrd_rd");
    idle_all();
    step(0, 0, "wrrd_drain");
  endtask

  task automatic test_reset_mid();
    p0_req = 1; p0_addr = 8'h07;
    step(1, 0, "rmid_rd");
    idle_all();
    rst_n = 0;
    q.delete();
    @(negedge clk);
    n_cmp++;
    if ({p0_rvalid, p1_rvalid, ram_ce} !== 3'b000) begin
      n_bad++;
      $display("FAIL rmid in reset: got %b%b%b want 000",
               p0_rvalid, p1_rvalid, ram_ce);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    step(0, 0, "rmid_no_rvalid");
    p0_req = 1; p0_addr = 8'h08;
    p1_req = 1; p1_addr = 8'h09;
    step(1, 0, "rmid_first_p0");
    idle_all();
    step(0, 0, "rmid_drain");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    ram_dout = 0;
    rst_n = 0;
    cfg_fixed_pri = 0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rr();
    test_single();
    test_fixed();
    test_lock();
    test_wrrd();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
